// File: rtl/lib_pkg.sv
// Shared type definitions for the execution units.
// alu_type_t : ALU operation select
// md_type_t  : multiply/divide operation select (bit 2 set = divide family)
package lib_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_type_t;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_type_t;

endpackage

// File: rtl/mdu.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide sharing one 2*WIDTH accumulator, one bit per CALC cycle.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             synchronous abort of any operation in flight
//   in_valid/in_ready request handshake; md_type, in0 (A), in1 (B) operands
//   out_valid/out_ready result handshake; out is the WIDTH-bit result
module mdu
  import lib_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  md_type_t         md_type,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_type_t         op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand or divisor magnitude
  logic [W2-1:0]    acc_q, acc_d;   // mul: {hi, multiplier/lo}; div: {rem, quo}
  logic             neg_q, neg_d;   // sign to apply to the selected result
  logic [WIDTH-1:0] out_q, out_d;

  logic             a_signed, b_signed, a_neg, b_neg, is_div, is_sdiv, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, res;
  logic [WIDTH:0]   rem_sh, diff, mul_sum;
  logic [W2-1:0]    acc_step, prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MUL;
      opa_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
    end
  end

  // Next state, iteration step and result selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    out_d   = out_q;

    // Operand conditioning for a new request
    is_div   = (md_type == MD_DIV) || (md_type == MD_DIVU) ||
               (md_type == MD_REM) || (md_type == MD_REMU);
    is_sdiv  = (md_type == MD_DIV) || (md_type == MD_REM);
    a_signed = (md_type == MD_MULH) || (md_type == MD_MULHSU) || is_sdiv;
    b_signed = (md_type == MD_MULH) || is_sdiv;
    a_neg    = a_signed & in0[WIDTH-1];
    b_neg    = b_signed & in1[WIDTH-1];
    a_mag    = a_neg ? -in0 : in0;
    b_mag    = b_neg ? -in1 : in1;
    div_ovf  = is_sdiv && (in0 == {1'b1, {(WIDTH-1){1'b0}}}) && (&in1);

    // One iteration of the current operation
    rem_sh  = acc_q[W2-1:WIDTH-1];
    diff    = rem_sh - {1'b0, opa_q};
    mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    if (op_q == MD_DIV || op_q == MD_DIVU || op_q == MD_REM || op_q == MD_REMU) begin
      // A borrow (diff MSB) means the divisor did not fit: restore.
      acc_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Signed result fix-up on the final accumulator value
    prod_s = neg_q ? -acc_step : acc_step;
    quo_s  = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_s  = neg_q ? -acc_step[W2-1:WIDTH] : acc_step[W2-1:WIDTH];
    case (op_q)
      MD_MUL:                       res = prod_s[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res = prod_s[W2-1:WIDTH];
      MD_DIV, MD_DIVU:              res = quo_s;
      MD_REM, MD_REMU:              res = rem_s;
      default:                      res = '0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          op_d  = md_type;
          cnt_d = '0;
          if (is_div && (in1 == '0)) begin
            out_d   = (md_type == MD_DIV || md_type == MD_DIVU) ? '1 : in0;
            state_d = S_DONE;
          end else if (div_ovf) begin
            out_d   = (md_type == MD_DIV) ? in0 : '0;
            state_d = S_DONE;
          end else if (is_div) begin
            opa_d   = b_mag;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            // Remainder takes the dividend sign, quotient the XOR of both.
            neg_d   = (md_type == MD_REM) ? a_neg : (a_neg ^ b_neg);
            state_d = S_CALC;
          end else begin
            opa_d   = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            neg_d   = a_neg ^ b_neg;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          out_d   = res;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width in bits; legal values are 8 to 64, even numbers only.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, SHALL set the iteration counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 flush  input  1  SHALL be a synchronous abort that discards any operation in flight.
REQ-006 in_valid  input  1  SHALL mark a valid operation request.
REQ-007 in_ready  output  1  SHALL indicate that the unit accepts a request this cycle.
REQ-008 md_type  input  md_type_t  SHALL select the operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
REQ-009 in0  input  WIDTH  SHALL carry operand A (multiplicand or dividend).
REQ-010 in1  input  WIDTH  SHALL carry operand B (multiplier or divisor).
REQ-011 out_valid  output  1  SHALL mark a valid result.
REQ-012 out_ready  input  1  SHALL indicate that the consumer takes the result.
REQ-013 out  output  WIDTH  SHALL carry the result.

Function
REQ-014 A request SHALL be accepted on any rising edge where in_valid, in_ready and !flush are all high; md_type, in0 and in1 SHALL be captured at that edge.
REQ-015 The FSM SHALL have the states IDLE, CALC and DONE; in_ready = (state==IDLE).
REQ-016 Transitions SHALL be:
- IDLE to CALC on accept;
- CALC to DONE after exactly WIDTH CALC cycles;
- DONE to IDLE when out_valid && out_ready;
- any state to IDLE on flush.
REQ-017 out_valid SHALL equal (state==DONE); out and out_valid SHALL hold stable while out_ready is low.
REQ-018 Multiplication SHALL be radix-2 shift-add over a 2*WIDTH product.
- Signed operands SHALL be converted to magnitude and the product sign applied at completion.
- MUL SHALL return the low WIDTH bits; MULH, MULHSU and MULHU SHALL return the high WIDTH bits.
- MULH treats both operands as signed; MULHSU treats in0 as signed and in1 as unsigned.
REQ-019 Division SHALL be restoring, one quotient bit per CALC cycle, on magnitudes.
- The quotient sign SHALL be sign(A) XOR sign(B); the remainder sign SHALL equal sign(A).
REQ-020 If the divisor is 0, the unit SHALL skip CALC (IDLE to DONE in one edge).
- DIV/DIVU SHALL return all-ones.
- REM/REMU SHALL return in0.
REQ-021 For signed overflow (DIV/REM with in0 = most-negative and in1 = -1), the unit SHALL skip CALC.
- DIV SHALL return in0.
- REM SHALL return 0.
REQ-022 Normal latency SHALL be WIDTH+1 edges from accept to first out_valid; special-case latency SHALL be 1 edge.
REQ-023 A new request SHALL be accepted no earlier than the edge after the DONE handshake; throughput SHALL be one operation per WIDTH+2 cycles minimum.
REQ-024 flush SHALL take precedence over in_valid, out_ready and completion on the same edge; a flushed result SHALL never appear.
REQ-025 An undefined md_type SHALL produce out = 0 at DONE.

Reset
REQ-026 On rst_n low the unit SHALL immediately force:
- state = IDLE;
- out_valid = 0;
- out = 0;
- all datapath registers and the counter = 0;
- in_ready = 1 after release.
REQ-027 Reset asserted mid-operation SHALL discard that operation; no result SHALL be emitted after release.

Structure
REQ-028 md_type_t (the 8 encodings, 3 bits) SHALL live in lib_pkg alongside alu_type_t; the state enum SHALL be local to mdu.
REQ-029 The unit SHALL be a single module with one FSM and a shared accumulator/shift register for multiply and divide; no sub-module.

Verification
REQ-030 MUL 7 x -3 (WIDTH=32), out_ready=1 SHALL give out=0xFFFFFFEB with out_valid first seen 33 edges after accept.
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF SHALL give 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 SHALL give 0x40000000.
REQ-032 Division cases SHALL be checked:
- DIV -7/2 SHALL give 0xFFFFFFFD and REM -7/2 SHALL give 0xFFFFFFFF;
- DIVU 100/0 SHALL give 0xFFFFFFFF in 1 edge;
- REM 0x80000000/-1 SHALL give 0.
REQ-033 out_ready held low for 5 cycles at DONE SHALL keep out_valid=1 and out stable with in_ready=0; raising out_ready SHALL give in_ready=1 on the next edge.
REQ-034 flush asserted 10 cycles into a DIV SHALL give out_valid=0 and in_ready=1 on the next edge; the following MUL 3 x 4 SHALL return 12.
REQ-035 rst_n pulsed low mid-CALC SHALL give out=0 and out_valid=0 immediately, with no spurious result after release.
